// File: rtl/periph_bus_router.sv
// periph_bus_router: single-master, multi-slave router for the MCU peripheral bus.
// Windowed address decode, registered slave side, error termination on decode miss or slave timeout.

module periph_addr_match #(
  parameter logic [31:0] BASE = 32'h0,
  parameter logic [31:0] MASK = 32'hFFFF_F000
) (
  input  logic [31:0] addr,
  output logic        hit
);
  assign hit = (addr & MASK) == (BASE & MASK);
endmodule

module periph_bus_router #(
  parameter int                         N_SLAVES       = 4,
  parameter logic [N_SLAVES-1:0][31:0]  SLV_BASE       = {N_SLAVES{32'h0}},
  parameter logic [N_SLAVES-1:0][31:0]  SLV_MASK       = {N_SLAVES{32'hFFFF_F000}},
  parameter int                         TIMEOUT_CYCLES = 255,
  parameter logic [31:0]                ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_valid,
  output logic                         m_ready,
  input  logic [31:0]                  m_addr,
  input  logic [31:0]                  m_wdata,
  input  logic [3:0]                   m_wstrb,
  output logic [31:0]                  m_rdata,
  output logic [N_SLAVES-1:0]          s_valid,
  input  logic [N_SLAVES-1:0]          s_ready,
  output logic [31:0]                  s_addr,
  output logic [31:0]                  s_wdata,
  output logic [3:0]                   s_wstrb,
  input  logic [N_SLAVES-1:0][31:0]    s_rdata,
  output logic                         bus_err,
  output logic [31:0]                  err_addr,
  input  logic                         err_clr
);

  localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_t               state, state_nxt;
  req_t                 req, req_nxt;
  logic [SW-1:0]        sel, sel_nxt, dec_sel;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [N_SLAVES-1:0]  hit, s_valid_nxt;
  logic                 dec_hit, m_ready_nxt, err_set, timeout;
  logic [31:0]          m_rdata_nxt, err_addr_nxt;

  // One window comparator per slave port.
  for (genvar i = 0; i < N_SLAVES; i++) begin : g_match
    periph_addr_match #(
      .BASE (SLV_BASE[i]),
      .MASK (SLV_MASK[i])
    ) u_match (
      .addr (m_addr),
      .hit  (hit[i])
    );
  end

  // Lowest index wins, so scan downward and let lower indices overwrite.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        dec_hit = 1'b1;
        dec_sel = SW'(i);
      end
    end
  end

  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  always_comb begin
    state_nxt    = state;
    req_nxt      = req;
    sel_nxt      = sel;
    cnt_nxt      = cnt;
    s_valid_nxt  = '0;
    m_ready_nxt  = 1'b0;
    m_rdata_nxt  = m_rdata;
    err_set      = 1'b0;
    err_addr_nxt = err_addr;
    unique case (state)
      IDLE: begin
        if (m_valid) begin
          req_nxt = '{addr: m_addr, wdata: m_wdata, wstrb: m_wstrb};
          cnt_nxt = '0;
          if (dec_hit) begin
            sel_nxt              = dec_sel;
            s_valid_nxt[dec_sel] = 1'b1;
            state_nxt            = ACTIVE;
          end else begin
            m_rdata_nxt  = ERR_RDATA;
            err_set      = 1'b1;
            err_addr_nxt = m_addr;
            m_ready_nxt  = 1'b1;
            state_nxt    = RESP;
          end
        end
      end
      ACTIVE: begin
        // A ready arriving on the timeout cycle still completes normally.
        if (s_ready[sel]) begin
          m_rdata_nxt = s_rdata[sel];
          cnt_nxt     = '0;
          m_ready_nxt = 1'b1;
          state_nxt   = RESP;
        end else if (timeout) begin
          m_rdata_nxt  = ERR_RDATA;
          err_set      = 1'b1;
          err_addr_nxt = req.addr;
          cnt_nxt      = '0;
          m_ready_nxt  = 1'b1;
          state_nxt    = RESP;
        end else begin
          s_valid_nxt[sel] = 1'b1;
          if (cnt != CNT_MAX) cnt_nxt = cnt + CW'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req      <= '0;
      sel      <= '0;
      cnt      <= '0;
      s_valid  <= '0;
      m_ready  <= 1'b0;
      m_rdata  <= '0;
      bus_err  <= 1'b0;
      err_addr <= '0;
    end else begin
      req      <= req_nxt;
      sel      <= sel_nxt;
      cnt      <= cnt_nxt;
      s_valid  <= s_valid_nxt;
      m_ready  <= m_ready_nxt;
      m_rdata  <= m_rdata_nxt;
      err_addr <= err_addr_nxt;
      // A new error outranks a coincident clear.
      if (err_set)      bus_err <= 1'b1;
      else if (err_clr) bus_err <= 1'b0;
    end
  end

  assign s_addr  = req.addr;
  assign s_wdata = req.wdata;
  assign s_wstrb = req.wstrb;

endmodule
